// File: rtl/r2r_dac_pkg.sv
// Shared types and helpers for the R2R ladder DAC front-end.
package r2r_dac_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DAC_W_DEFAULT = 8;
  localparam int DIV_W_DEFAULT = 16;
  localparam int DAC_W_MAX     = 12;

  // Full-scale ladder code for a given resolution, right-aligned in the widest legal ladder.
  function automatic logic [DAC_W_MAX-1:0] max_code(input int width);
    return DAC_W_MAX'((1 << width) - 1);
  endfunction

endpackage

// File: rtl/r2r_wave_gen_if.sv
// Config and direct-sample handshake channels between the pin decode logic and the DAC front-end.
interface r2r_wave_gen_if
  import r2r_dac_pkg::*;
#(
  parameter int DAC_W = DAC_W_DEFAULT,
  parameter int DIV_W = DIV_W_DEFAULT
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;
  logic [DAC_W-1:0] cfg_step;

  logic             smp_valid;
  logic             smp_ready;
  logic [DAC_W-1:0] smp_data;

  modport master (
    output cfg_valid, cfg_mode, cfg_div, cfg_step, smp_valid, smp_data,
    input  cfg_ready, smp_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_div, cfg_step, smp_valid, smp_data,
    output cfg_ready, smp_ready
  );

endinterface

// File: rtl/r2r_prescaler.sv
// Sample-rate prescaler: counts 0..div while enabled and fires a tick on the wrap.
module r2r_prescaler
  import r2r_dac_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = en && (count == div);

  // A config apply restarts the sample period so the new divider starts from a clean phase.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/r2r_wave_gen.sv
// Digital front-end for the R2R ladder DAC: streams host samples or generates
// saw/triangle/square codes, with config changes landing only on sample boundaries.
module r2r_wave_gen
  import r2r_dac_pkg::*;
#(
  parameter int DAC_W = DAC_W_DEFAULT,
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  r2r_wave_gen_if.slave    bus,
  output logic [DAC_W-1:0] dac_code,
  output logic             tick,
  output logic             underrun
);

  localparam logic [DAC_W-1:0] MAX = DAC_W'(max_code(DAC_W));

  mode_e            mode;
  logic [DIV_W-1:0] div;
  logic [DAC_W-1:0] step;
  dir_e             dir;
  dir_e             dir_nxt;
  logic [DAC_W-1:0] code_nxt;

  logic             cfg_free;
  mode_e            pend_mode;
  logic [DIV_W-1:0] pend_div;
  logic [DAC_W-1:0] pend_step;

  logic             buf_empty;
  logic [DAC_W-1:0] buf_data;

  logic int_tick;
  logic cfg_accept;
  logic smp_accept;
  logic apply;
  logic advance;
  logic consume;
  logic starve;

  assign bus.cfg_ready = cfg_free;
  assign bus.smp_ready = buf_empty;

  assign cfg_accept = bus.cfg_valid && cfg_free;
  assign smp_accept = bus.smp_valid && buf_empty;
  // While running, a pending config waits for a sample boundary; while frozen it lands at once.
  assign apply      = !cfg_free && (int_tick || !en);
  assign advance    = int_tick && !apply;
  assign consume    = advance && (mode == MODE_DIRECT) && !buf_empty;
  assign starve     = advance && (mode == MODE_DIRECT) && buf_empty;

  r2r_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (apply),
    .div   (div),
    .tick  (int_tick)
  );

  always_comb begin
    code_nxt = dac_code;
    dir_nxt  = dir;
    if (apply) begin
      code_nxt = '0;
      dir_nxt  = DIR_UP;
    end else if (advance) begin
      case (mode)
        MODE_DIRECT: begin
          if (!buf_empty) code_nxt = buf_data;
        end
        MODE_SAW: code_nxt = dac_code + step;
        // Compare against MAX-step / step so the turn-around never overflows the ladder width.
        MODE_TRI: begin
          if (dir == DIR_UP) begin
            if (dac_code > MAX - step) begin
              code_nxt = MAX;
              dir_nxt  = DIR_DOWN;
            end else begin
              code_nxt = dac_code + step;
            end
          end else begin
            if (dac_code < step) begin
              code_nxt = '0;
              dir_nxt  = DIR_UP;
            end else begin
              code_nxt = dac_code - step;
            end
          end
        end
        MODE_SQUARE: code_nxt = (dac_code == '0) ? MAX : '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_code <= '0;
      dir      <= DIR_UP;
      tick     <= 1'b0;
    end else begin
      dac_code <= code_nxt;
      dir      <= dir_nxt;
      tick     <= int_tick;
    end
  end

  // Config slot, active config, sample buffer and the sticky underrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode      <= MODE_DIRECT;
      div       <= '0;
      step      <= DAC_W'(1);
      cfg_free  <= 1'b1;
      pend_mode <= MODE_DIRECT;
      pend_div  <= '0;
      pend_step <= '0;
      buf_empty <= 1'b1;
      buf_data  <= '0;
      underrun  <= 1'b0;
    end else begin
      if (cfg_accept) begin
        cfg_free  <= 1'b0;
        pend_mode <= mode_e'(bus.cfg_mode);
        pend_div  <= bus.cfg_div;
        pend_step <= bus.cfg_step;
      end else if (apply) begin
        cfg_free <= 1'b1;
        mode     <= pend_mode;
        div      <= pend_div;
        step     <= pend_step;
      end

      if (smp_accept) begin
        buf_empty <= 1'b0;
        buf_data  <= bus.smp_data;
      end else if (consume) begin
        buf_empty <= 1'b1;
      end

      if (apply) begin
        underrun <= 1'b0;
      end else if (starve) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_r2r_wave_gen.sv
// Scoreboard bench for r2r_wave_gen: stimulus queues expected tick codes, a monitor checks each tick.
module tb_r2r_wave_gen;
  import r2r_dac_pkg::*;

  localparam int DAC_W = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DAC_W-1:0] dac_code;
  logic             tick;
  logic             underrun;

  r2r_wave_gen_if #(.DAC_W(DAC_W), .DIV_W(DIV_W)) bus ();

  r2r_wave_gen #(.DAC_W(DAC_W), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .dac_code (dac_code),
    .tick     (tick),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int ur;
    int gap;
  } exp_t;

  exp_t             exp_q[$];
  logic [DAC_W-1:0] smp_q[$];
  int               total = 0;
  int               bad = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input int code, input int ur, input int gap);
    exp_t e;
    e.code = code;
    e.ur   = ur;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  // Offers a config and waits (bounded) for the handshake; the slot must then read busy.
  task automatic applyStimulus(input mode_e mode, input int div, input int step);
    logic rdy;
    int   n;
    n = 0;
    bus.cfg_mode  = mode;
    bus.cfg_div   = DIV_W'(div);
    bus.cfg_step  = DAC_W'(step);
    bus.cfg_valid = 1'b1;
    do begin
      rdy = bus.cfg_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    bus.cfg_valid = 1'b0;
    checkOutput("cfg_accepted", int'(rdy), 1);
    checkOutput("cfg_ready_pending", int'(bus.cfg_ready), 0);
  endtask

  task automatic cfg_idle(input mode_e mode, input int div, input int step);
    applyStimulus(mode, div, step);
    @(posedge clk);
    #1;
    checkOutput("apply_cfg_ready", int'(bus.cfg_ready), 1);
    checkOutput("apply_code", int'(dac_code), 0);
    checkOutput("apply_tick", int'(tick), 0);
    checkOutput("apply_underrun", int'(underrun), 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    en = 1'b0;
    checkOutput("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : monitor
    int   cyc;
    int   last;
    exp_t e;
    cyc  = 0;
    last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_tick", int'(tick), 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tick_code", int'(dac_code), e.code);
          checkOutput("tick_underrun", int'(underrun), e.ur);
          if (e.gap >= 0) checkOutput("tick_gap", cyc - last, e.gap);
          last = cyc;
        end
      end
    end
  end

  initial begin : feeder
    logic rdy;
    bus.smp_valid = 1'b0;
    bus.smp_data  = '0;
    forever begin
      if (smp_q.size() != 0) begin
        bus.smp_valid = 1'b1;
        bus.smp_data  = smp_q[0];
      end else begin
        bus.smp_valid = 1'b0;
      end
      rdy = bus.smp_ready;
      @(posedge clk);
      if (bus.smp_valid && rdy && !rst) void'(smp_q.pop_front());
      #1;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst           = 1'b1;
    en            = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_mode  = '0;
    bus.cfg_div   = '0;
    bus.cfg_step  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_code", int'(dac_code), 0);
    checkOutput("reset_tick", int'(tick), 0);
    checkOutput("reset_underrun", int'(underrun), 0);
    checkOutput("reset_cfg_ready", int'(bus.cfg_ready), 1);
    checkOutput("reset_smp_ready", int'(bus.smp_ready), 1);
    rst = 1'b0;

    $display("[TB] default DIRECT, div=0, empty buffer");
    for (int i = 0; i < 3; i++) push_exp(8'h00, 1, (i == 0) ? -1 : 1);
    @(negedge clk);
    #1;
    en = 1'b1;
    drain(20);

    $display("[TB] DIRECT div=3 streaming");
    cfg_idle(MODE_DIRECT, 3, 1);
    smp_q.push_back(8'h10);
    smp_q.push_back(8'h20);
    smp_q.push_back(8'h30);
    repeat (3) @(negedge clk);
    #1;
    push_exp(8'h10, 0, -1);
    push_exp(8'h20, 0, 4);
    push_exp(8'h30, 0, 4);
    push_exp(8'h30, 1, 4);
    en = 1'b1;
    drain(60);

    $display("[TB] SAW step=0x40");
    cfg_idle(MODE_SAW, 0, 'h40);
    push_exp(8'h40, 0, -1);
    push_exp(8'h80, 0, 1);
    push_exp(8'hC0, 0, 1);
    push_exp(8'h00, 0, 1);
    push_exp(8'h40, 0, 1);
    @(negedge clk);
    #1;
    en = 1'b1;
    drain(30);

    $display("[TB] TRI step=0x60");
    cfg_idle(MODE_TRI, 0, 'h60);
    push_exp(8'h60, 0, -1);
    push_exp(8'hC0, 0, 1);
    push_exp(8'hFF, 0, 1);
    push_exp(8'h9F, 0, 1);
    push_exp(8'h3F, 0, 1);
    push_exp(8'h00, 0, 1);
    push_exp(8'h60, 0, 1);
    push_exp(8'hC0, 0, 1);
    @(negedge clk);
    #1;
    en = 1'b1;
    drain(30);

    $display("[TB] reset mid-TRI with a buffered sample");
    smp_q.push_back(8'h55);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("smp_ready_full", int'(bus.smp_ready), 0);
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_code", int'(dac_code), 0);
    checkOutput("midrst_tick", int'(tick), 0);
    checkOutput("midrst_underrun", int'(underrun), 0);
    checkOutput("midrst_cfg_ready", int'(bus.cfg_ready), 1);
    checkOutput("midrst_smp_ready", int'(bus.smp_ready), 1);
    rst = 1'b0;
    en  = 1'b0;

    $display("[TB] cfg accept coinciding with a tick");
    push_exp(8'h00, 1, -1);
    push_exp(8'h00, 0, 1);
    push_exp(8'h20, 0, 1);
    push_exp(8'h40, 0, 1);
    @(negedge clk);
    #1;
    en = 1'b1;
    applyStimulus(MODE_SAW, 0, 'h20);
    drain(30);

    $display("[TB] SQUARE div=1 then mid-period reconfig");
    cfg_idle(MODE_SQUARE, 1, 0);
    push_exp(8'hFF, 0, -1);
    push_exp(8'h00, 0, 2);
    push_exp(8'hFF, 0, 2);
    push_exp(8'h00, 0, 2);
    @(negedge clk);
    #1;
    en = 1'b1;
    drain(30);
    push_exp(8'h00, 0, -1);
    push_exp(8'h10, 0, 2);
    push_exp(8'h20, 0, 2);
    en = 1'b1;
    applyStimulus(MODE_SAW, 1, 'h10);
    @(posedge clk);
    #1;
    checkOutput("cfg_ready_after_apply", int'(bus.cfg_ready), 1);
    drain(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
